// File: rtl/rv_pkg.sv
// Shared RV32I core types and sizing for the integer register file.
// Consumed by reg_file_2r1w, its interface and its read ports.
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam word_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register file access bundle: two read ports and one write port.
// master = decode/writeback side, slave = register file.
interface reg_file_2r1w_if;
  import rv_pkg::*;

  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  reg_addr_t rd_addr_i;
  word_t     rd_data_i;
  logic      rd_wren_i;
  word_t     rs1_data_o;
  word_t     rs2_data_o;

  modport master (
    output rs1_addr_i,
    output rs2_addr_i,
    output rd_addr_i,
    output rd_data_i,
    output rd_wren_i,
    input  rs1_data_o,
    input  rs2_data_o
  );

  modport slave (
    input  rs1_addr_i,
    input  rs2_addr_i,
    input  rd_addr_i,
    input  rd_data_i,
    input  rd_wren_i,
    output rs1_data_o,
    output rs2_data_o
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational register read port: binary mux tree, x0 forced to 0.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module rf_read_port
  import rv_pkg::*;
(
  input  logic [NUM_REGS*XLEN-1:0] regs_flat,
  input  reg_addr_t                addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                     rst,
  input  logic                     wr_en,
  input  reg_addr_t                wr_addr,
  input  word_t                    wr_data,
`endif
  output word_t                    data
);

  word_t sel;

  // Balanced select: each level halves the candidates on one address bit.
  always_comb begin
    word_t tree [NUM_REGS];
    for (int k = 0; k < NUM_REGS; k++) begin
      tree[k] = regs_flat[k*XLEN +: XLEN];
    end
    for (int l = 0; l < ADDR_W; l++) begin
      for (int n = 0; n < (NUM_REGS >> (l + 1)); n++) begin
        tree[n] = addr[l] ? tree[2*n+1] : tree[2*n];
      end
    end
    sel = tree[0];
  end

  // x0 reads as zero; forwarding never targets x0 or applies during reset.
  always_comb begin
    data = sel;
    if (addr == '0) data = REG_ZERO;
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_en && (wr_addr != '0) && (wr_addr == addr))
      data = wr_data;
`endif
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// RV32I integer register file, 32x32, 2 combinational reads, 1 sync write.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through reads.
module reg_file_2r1w
  import rv_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  reg_file_2r1w_if.slave  rf
);

  word_t                     regs [1:NUM_REGS-1];
  logic [NUM_REGS*XLEN-1:0]  regs_flat;

  // Sync clear has priority; writes to x0 are dropped (no x0 storage).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= REG_ZERO;
    end else if (rf.rd_wren_i && (rf.rd_addr_i != '0)) begin
      regs[rf.rd_addr_i] <= rf.rd_data_i;
    end
  end

  assign regs_flat[XLEN-1:0] = REG_ZERO;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*XLEN +: XLEN] = regs[gi];
  end

  rf_read_port u_rs1 (
    .regs_flat (regs_flat),
    .addr      (rf.rs1_addr_i),
`ifdef REGFILE_BYPASS_EN
    .rst       (rst_i),
    .wr_en     (rf.rd_wren_i),
    .wr_addr   (rf.rd_addr_i),
    .wr_data   (rf.rd_data_i),
`endif
    .data      (rf.rs1_data_o)
  );

  rf_read_port u_rs2 (
    .regs_flat (regs_flat),
    .addr      (rf.rs2_addr_i),
`ifdef REGFILE_BYPASS_EN
    .rst       (rst_i),
    .wr_en     (rf.rd_wren_i),
    .wr_addr   (rf.rd_addr_i),
    .wr_data   (rf.rd_data_i),
`endif
    .data      (rf.rs2_data_o)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
// Expectations follow REGFILE_BYPASS_EN for the same-cycle hazard case.
module tb_reg_file_2r1w;
  import rv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_file_2r1w_if rf_bus ();

  reg_file_2r1w dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf    (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input reg_addr_t a, input word_t d);
    rf_bus.rd_addr_i = a;
    rf_bus.rd_data_i = d;
    rf_bus.rd_wren_i = 1'b1;
    tick();
    rf_bus.rd_wren_i = 1'b0;
  endtask

  task automatic rd(input reg_addr_t a1, input reg_addr_t a2);
    rf_bus.rs1_addr_i = a1;
    rf_bus.rs2_addr_i = a2;
    #1;
  endtask

  initial begin
    word_t e1;
    word_t e2;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    rf_bus.rs1_addr_i = '0;
    rf_bus.rs2_addr_i = '0;
    rf_bus.rd_addr_i  = '0;
    rf_bus.rd_data_i  = '0;
    rf_bus.rd_wren_i  = 1'b0;
    tick();
    rst = 1'b0;

    rd(5'd1, 5'd31);
    check("init_rs1_x1", rf_bus.rs1_data_o, 32'h0);
    check("init_rs2_x31", rf_bus.rs2_data_o, 32'h0);

    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    check("preload_x5", rf_bus.rs1_data_o, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(5'd5, 5'd31);
    check("rst_rs1_x5", rf_bus.rs1_data_o, 32'h0);
    check("rst_rs2_x31", rf_bus.rs2_data_o, 32'h0);

    wr(5'd1, 32'h12345678);
    wr(5'd2, 32'h000000FF);
    rd(5'd1, 5'd2);
    check("basic_rs1_x1", rf_bus.rs1_data_o, 32'h12345678);
    check("basic_rs2_x2", rf_bus.rs2_data_o, 32'h000000FF);
    rd(5'd2, 5'd1);
    check("swap_rs1_x2", rf_bus.rs1_data_o, 32'h000000FF);
    check("swap_rs2_x1", rf_bus.rs2_data_o, 32'h12345678);
    rd(5'd1, 5'd1);
    check("same_addr_rs2", rf_bus.rs2_data_o, 32'h12345678);

    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    check("x0_rs1", rf_bus.rs1_data_o, 32'h0);
    check("x0_rs2", rf_bus.rs2_data_o, 32'h0);
    tick();
    check("x0_later", rf_bus.rs1_data_o, 32'h0);

    rf_bus.rd_addr_i = 5'd1;
    rf_bus.rd_data_i = 32'hCAFEF00D;
    tick();
    rd(5'd1, 5'd2);
    check("wren0_x1", rf_bus.rs1_data_o, 32'h12345678);

    wr(5'd3, 32'hAAAAAAAA);
    rd(5'd3, 5'd0);
    rf_bus.rd_addr_i = 5'd3;
    rf_bus.rd_data_i = 32'h55555555;
    rf_bus.rd_wren_i = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_same", rf_bus.rs1_data_o, 32'h55555555);
`else
    check("hazard_same", rf_bus.rs1_data_o, 32'hAAAAAAAA);
`endif
    check("hazard_rs2_x0", rf_bus.rs2_data_o, 32'h0);
    tick();
    rf_bus.rd_wren_i = 1'b0;
    #1;
    check("hazard_next", rf_bus.rs1_data_o, 32'h55555555);

    rd(5'd7, 5'd3);
    rf_bus.rd_addr_i = 5'd7;
    rf_bus.rd_data_i = 32'h1;
    rf_bus.rd_wren_i = 1'b1;
    rst = 1'b1;
    #1;
    check("rstwr_during", rf_bus.rs1_data_o, 32'h0);
    tick();
    rst = 1'b0;
    rf_bus.rd_wren_i = 1'b0;
    #1;
    check("rstwr_x7", rf_bus.rs1_data_o, 32'h0);
    check("rstwr_x3", rf_bus.rs2_data_o, 32'h0);

    for (int i = 1; i < 32; i++) begin
      wr(reg_addr_t'(i), word_t'(i) * 32'h01010101);
    end
    for (int i = 0; i < 32; i++) begin
      rd(reg_addr_t'(i), reg_addr_t'(31 - i));
      e1 = word_t'(i) * 32'h01010101;
      e2 = word_t'(31 - i) * 32'h01010101;
      check($sformatf("sweep_rs1_x%0d", i), rf_bus.rs1_data_o, e1);
      check($sformatf("sweep_rs2_x%0d", 31 - i), rf_bus.rs2_data_o, e2);
    end
    rd(5'd31, 5'd16);
    check("sweep_x31", rf_bus.rs1_data_o, 32'h1F1F1F1F);
    check("sweep_x16", rf_bus.rs2_data_o, 32'h10101010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
